// File: rtl/vga_timing_gen_pkg.sv
// Shared SVGA 800x600@60 timing constants and counter widths, so the render
// pipeline and the timing generator agree on the same numbers.
package vga_timing_gen_pkg;

  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BP     = 88;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 1056

  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 4;
  localparam int V_BP     = 23;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 628

  localparam int H_CNT_W  = 11;
  localparam int V_CNT_W  = 10;

  // Map "inside the sync window" onto the pin level for the chosen polarity.
  function automatic logic sync_level(input logic in_win, input logic pol);
    return in_win ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: advance enable in, sync/enable/coordinates/ticks out.
interface vga_timing_gen_if;
  import vga_timing_gen_pkg::*;

  logic               en;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic [H_CNT_W-1:0] pix_x;
  logic [V_CNT_W-1:0] pix_y;
  logic               line_tick;
  logic               frame_tick;

  // Timing generator side.
  modport master (
    input  en,
    output hsync, vsync, de, pix_x, pix_y, line_tick, frame_tick
  );

  // Consumer side (render pipeline / pin driver / game logic).
  modport slave (
    output en,
    input  hsync, vsync, de, pix_x, pix_y, line_tick, frame_tick
  );
endinterface

// File: rtl/vga_timing_gen_timing_axis_cnt.sv
// Generic wrapping counter for one raster axis, with terminal-count flag and
// active / sync window decode of the current count.
module timing_axis_cnt #(
  parameter int W          = 11,
  parameter int TOTAL      = 1056,
  parameter int ACT_END    = 800,
  parameter int SYNC_START = 840,
  parameter int SYNC_END   = 968
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_adv,
  output logic [W-1:0] o_cnt,
  output logic         o_tc,
  output logic         o_active,
  output logic         o_sync_win
);

  // Window bounds are compared one bit wider so a bound equal to 2**W
  // (window running to the very end of a full-width axis) does not wrap.
  localparam logic [W-1:0] L_LAST       = W'(TOTAL - 1);
  localparam logic [W:0]   L_ACT_END    = (W+1)'(ACT_END);
  localparam logic [W:0]   L_SYNC_START = (W+1)'(SYNC_START);
  localparam logic [W:0]   L_SYNC_END   = (W+1)'(SYNC_END);

  logic [W-1:0] r_cnt;
  logic [W:0]   w_cnt_ext;

  assign w_cnt_ext  = {1'b0, r_cnt};
  assign o_cnt      = r_cnt;
  assign o_tc       = (r_cnt == L_LAST);
  assign o_active   = (w_cnt_ext < L_ACT_END);
  assign o_sync_win = (w_cnt_ext >= L_SYNC_START) && (w_cnt_ext < L_SYNC_END);

  // Count up while advancing, wrapping to zero after the last position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_adv) begin
      r_cnt <= o_tc ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// SVGA raster timing generator: horizontal/vertical counters plus a registered
// decode stage so every output shares the same one-cycle latency.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE = vga_timing_gen_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_gen_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_gen_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_gen_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_gen_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_gen_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_gen_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_gen_pkg::V_BP,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  vga_timing_gen_if.master    vga
);

  localparam int L_H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int L_V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [H_CNT_W-1:0] w_h_cnt;
  logic [V_CNT_W-1:0] w_v_cnt;
  logic               w_h_tc;
  logic               w_v_tc;
  logic               w_h_act;
  logic               w_v_act;
  logic               w_h_sync;
  logic               w_v_sync;
  logic               w_v_adv;
  logic               w_line_start;
  logic               w_frame_start;

  // The vertical axis only moves on the last pixel of a line.
  assign w_v_adv = vga.en && w_h_tc;

  timing_axis_cnt #(
    .W          (H_CNT_W),
    .TOTAL      (L_H_TOT),
    .ACT_END    (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
  ) u_h_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_adv      (vga.en),
    .o_cnt      (w_h_cnt),
    .o_tc       (w_h_tc),
    .o_active   (w_h_act),
    .o_sync_win (w_h_sync)
  );

  timing_axis_cnt #(
    .W          (V_CNT_W),
    .TOTAL      (L_V_TOT),
    .ACT_END    (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
  ) u_v_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_adv      (w_v_adv),
    .o_cnt      (w_v_cnt),
    .o_tc       (w_v_tc),
    .o_active   (w_v_act),
    .o_sync_win (w_v_sync)
  );

  assign w_line_start  = (w_h_cnt == '0);
  assign w_frame_start = w_line_start && (w_v_cnt == V_CNT_W'(V_ACTIVE));

  logic               r_hsync;
  logic               r_vsync;
  logic               r_de;
  logic [H_CNT_W-1:0] r_pix_x;
  logic [V_CNT_W-1:0] r_pix_y;
  logic               r_line_tick;
  logic               r_frame_tick;

  // Register the decoded counter state; while stalled everything holds except
  // the ticks, which drop so a single event is never reported twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync      <= ~SYNC_POL;
      r_vsync      <= ~SYNC_POL;
      r_de         <= 1'b0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_line_tick  <= 1'b0;
      r_frame_tick <= 1'b0;
    end else if (vga.en) begin
      r_hsync      <= sync_level(w_h_sync, SYNC_POL);
      r_vsync      <= sync_level(w_v_sync, SYNC_POL);
      r_de         <= w_h_act && w_v_act;
      r_pix_x      <= w_h_cnt;
      r_pix_y      <= w_v_cnt;
      r_line_tick  <= w_line_start;
      r_frame_tick <= w_frame_start;
    end else begin
      r_line_tick  <= 1'b0;
      r_frame_tick <= 1'b0;
    end
  end

  assign vga.hsync      = r_hsync;
  assign vga.vsync      = r_vsync;
  assign vga.de         = r_de;
  assign vga.pix_x      = r_pix_x;
  assign vga.pix_y      = r_pix_y;
  assign vga.line_tick  = r_line_tick;
  assign vga.frame_tick = r_frame_tick;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Consumes the 40 MHz pixel clock from the clock manager and generates SVGA 800x600@60 Hz raster timing: hsync, vsync, display-enable, pixel coordinates.
- Emits a one-cycle frame_tick at the start of vertical blanking. Game logic uses it as its frame-synchronous update strobe, replacing the free-running 60 Hz divider in the pixel domain.
- Feeds the sprite/render pipeline and the VGA output pins.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync pulse width (pixels)
- H_BP, 88, horizontal back porch (pixels); H_TOTAL = 1056
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BP, 23, vertical back porch (lines); V_TOTAL = 628
- SYNC_POL, 1, active level of hsync/vsync (1 = positive)

Ports:
- clk  in  1  40 MHz pixel clock
- rst_n  in  1  asynchronous reset, active-low
- en  in  1  advance enable (tie to clock-wizard locked); counters hold while low
- hsync  out  1  horizontal sync, level per SYNC_POL
- vsync  out  1  vertical sync, level per SYNC_POL
- de  out  1  display enable, high in visible area
- pix_x  out  11  current column, 0..H_TOTAL-1
- pix_y  out  10  current line, 0..V_TOTAL-1
- line_tick  out  1  one-cycle pulse at the first pixel of every line (h=0)
- frame_tick  out  1  one-cycle pulse at h=0, v=V_ACTIVE (start of vblank)

Behaviour:
- Internal counters h_cnt (11 b), v_cnt (10 b).
- When en=1, h_cnt increments each clk. At H_TOTAL-1 it wraps to 0 and v_cnt increments. v_cnt wraps from V_TOTAL-1 to 0 in the same cycle h_cnt wraps.
- When en=0, counters and all outputs hold their values. line_tick and frame_tick are forced 0 while en=0 so no pulse is repeated.
- All outputs are registered, decoded from the counter state. Output latency is 1 clk from the counter value; all outputs stay mutually aligned.
- de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- hsync = SYNC_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (pixels 840..967); otherwise ~SYNC_POL.
- vsync = SYNC_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (lines 601..604); otherwise ~SYNC_POL.
- pix_x/pix_y are the raw counter values and are valid in blanking too. Consumers qualify with de.
- line_tick = 1 for exactly one cycle when h_cnt==0.
- frame_tick = 1 for exactly one cycle when h_cnt==0 and v_cnt==V_ACTIVE. One pulse per 663168 advancing cycles (60.32 Hz at 40 MHz).
- Reset (rst_n low, asynchronous, any time including mid-line):
  - counters = 0, pix_x = 0, pix_y = 0
  - hsync = vsync = ~SYNC_POL
  - de = 0, line_tick = 0, frame_tick = 0
- After rst_n deasserts with en=1:
  - first rising edge loads outputs for (0,0): de=1, line_tick=1.
  - No frame_tick until v_cnt reaches V_ACTIVE.
- Comparisons use counter widths; parameter values must satisfy H_TOTAL <= 2048 and V_TOTAL <= 1024.

Decomposition:
- Shared header (define.v) holds the SVGA timing constants (H_*/V_* values, H_TOTAL, V_TOTAL) and counter bit lengths, so the render pipeline uses identical numbers.
- One natural sub-module: timing_axis_cnt, a generic wrapping counter with terminal-count output and sync/active window decode. It is instantiated twice: horizontal (advanced by en) and vertical (advanced by en && h terminal count).

Test Plan:
- Reset then en=1 for 1 line → first de=1 at pix_x=0; de falls after 800 cycles. hsync=1 for exactly 128 cycles starting at pix_x=840. line_tick period is 1056 cycles.
- Run 1 full frame → frame_tick pulses once at pix_x=0, pix_y=600. Next frame_tick arrives exactly 663168 cycles later. vsync=1 for exactly 4224 cycles (lines 601..604).
- Wrap check → at pix_x=1055, pix_y=627 the next cycle shows pix_x=0, pix_y=0, de=1, line_tick=1, frame_tick=0.
- en held low for 50 cycles mid-line at pix_x=400 → outputs frozen, no tick pulses. Resume continues at pix_x=401.
- rst_n asserted asynchronously at pix_x=900, pix_y=602 (hsync and vsync active) → outputs immediately 0/idle with hsync=vsync=0. Restart from (0,0).
- SYNC_POL=0 build → hsync/vsync idle high, low only in their windows; de and tick timing unchanged.
